// File: rtl/switch_link_tx.sv
// Link transmitter: serializes one switch flit into PHIT_W phits (LSB first) and registers remote credit pulses back to the switch.
// Optional trailing XOR-parity phit when SWITCH_LINK_TX_PARITY_EN is defined.
module switch_link_tx #(
  parameter int FLIT_W  = 64,
  parameter int PHIT_W  = 8,
  parameter int NUM_VCS = 2
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [FLIT_W-1:0]  flit_in,
  input  logic               flit_valid,
  output logic               packet_sent,
  output logic [NUM_VCS-1:0] credit_granted,
  output logic [PHIT_W-1:0]  phy_data,
  output logic               phy_valid,
  input  logic               phy_ready,
  input  logic [NUM_VCS-1:0] phy_credit_in
);

  localparam int NPHITS = (FLIT_W + PHIT_W - 1) / PHIT_W;
  localparam int CNT_W  = (NPHITS > 1) ? $clog2(NPHITS) : 1;
  localparam int PAD_W  = NPHITS * PHIT_W;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPHITS - 1);

`ifdef SWITCH_LINK_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PAR = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t              state_q;
  logic [FLIT_W-1:0]   flit_q;
  logic [CNT_W-1:0]    idx_q;
  logic [CNT_W-1:0]    idx_d;
  logic [PAD_W-1:0]    flit_pad;
  logic [PHIT_W-1:0]   next_phit_d;
  logic [PHIT_W-1:0]   phy_data_q;
  logic                phy_valid_q;
  logic                packet_sent_q;
  logic [NUM_VCS-1:0]  credit_q;

  // Zero-extend the held flit so the final phit is padded with zeros.
  always_comb begin
    flit_pad                = '0;
    flit_pad[FLIT_W-1:0]    = flit_q;
    idx_d                   = idx_q + CNT_W'(1);
    next_phit_d             = flit_pad[int'(idx_d)*PHIT_W +: PHIT_W];
  end

`ifdef SWITCH_LINK_TX_PARITY_EN
  logic [PHIT_W-1:0] parity_d;
  always_comb begin
    parity_d = '0;
    for (int i = 0; i < NPHITS; i++) begin
      parity_d = parity_d ^ flit_pad[i*PHIT_W +: PHIT_W];
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      flit_q        <= '0;
      phy_valid_q   <= 1'b0;
      phy_data_q    <= '0;
      packet_sent_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          packet_sent_q <= 1'b0;
          if (flit_valid) begin
            flit_q      <= flit_in;
            idx_q       <= '0;
            phy_valid_q <= 1'b1;
            phy_data_q  <= flit_in[PHIT_W-1:0];
            state_q     <= SEND;
          end
        end
        SEND: begin
          if (phy_ready) begin
            if (idx_q == LAST_IDX) begin
`ifdef SWITCH_LINK_TX_PARITY_EN
              phy_data_q    <= parity_d;
              state_q       <= PAR;
`else
              phy_valid_q   <= 1'b0;
              phy_data_q    <= '0;
              packet_sent_q <= 1'b1;
              state_q       <= DONE;
`endif
            end else begin
              idx_q      <= idx_d;
              phy_data_q <= next_phit_d;
            end
          end
        end
`ifdef SWITCH_LINK_TX_PARITY_EN
        PAR: begin
          if (phy_ready) begin
            phy_valid_q   <= 1'b0;
            phy_data_q    <= '0;
            packet_sent_q <= 1'b1;
            state_q       <= DONE;
          end
        end
`endif
        // flit_valid is deliberately ignored here so a held flit is not re-captured.
        DONE: begin
          packet_sent_q <= 1'b0;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (n_rst) credit_q <= '0;
    else       credit_q <= phy_credit_in;
  end

  assign phy_data       = phy_data_q;
  assign phy_valid      = phy_valid_q;
  assign packet_sent    = packet_sent_q;
  assign credit_granted = credit_q;

endmodule

// File: tb/tb_switch_link_tx.sv
// Directed bench for switch_link_tx (8-bit and 24-bit phit instances); follows SWITCH_LINK_TX_PARITY_EN.
module tb_switch_link_tx;

`ifdef SWITCH_LINK_TX_PARITY_EN
  localparam int PARN = 1;
`else
  localparam int PARN = 0;
`endif
  localparam logic [63:0] F1 = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] F2 = 64'hFFFF_0000_FFFF_0000;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic [63:0] flit_in = '0;
  logic        flit_valid = 1'b0;
  logic        phy_ready = 1'b0;
  logic [1:0]  phy_credit_in = '0;
  logic        packet_sent;
  logic [1:0]  credit_granted;
  logic [7:0]  phy_data;
  logic        phy_valid;

  logic [63:0] flit_in24 = '0;
  logic        flit_valid24 = 1'b0;
  logic        phy_ready24 = 1'b1;
  logic        packet_sent24;
  logic [1:0]  credit_granted24;
  logic [23:0] phy_data24;
  logic        phy_valid24;

  int n_cmp = 0;
  int n_bad = 0;
  logic [7:0] got_phits [0:15];

  always #5 clk = ~clk;

  switch_link_tx #(.FLIT_W(64), .PHIT_W(8), .NUM_VCS(2)) u_dut (
    .clk(clk), .n_rst(n_rst), .flit_in(flit_in), .flit_valid(flit_valid),
    .packet_sent(packet_sent), .credit_granted(credit_granted),
    .phy_data(phy_data), .phy_valid(phy_valid), .phy_ready(phy_ready),
    .phy_credit_in(phy_credit_in)
  );

  switch_link_tx #(.FLIT_W(64), .PHIT_W(24), .NUM_VCS(2)) u_dut24 (
    .clk(clk), .n_rst(n_rst), .flit_in(flit_in24), .flit_valid(flit_valid24),
    .packet_sent(packet_sent24), .credit_granted(credit_granted24),
    .phy_data(phy_data24), .phy_valid(phy_valid24), .phy_ready(phy_ready24),
    .phy_credit_in(2'b00)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the capture cycle (cycle 0); returns in the packet_sent cycle with flit_valid still high.
  task automatic send_and_check(input logic [63:0] f, input int st_lo, input int st_hi, input string tag);
    logic [7:0] exp_ph [0:8];
    logic [7:0] par;
    int k, cyc, stalls, nph_tot;
    par = '0;
    for (int i = 0; i < 8; i++) begin
      exp_ph[i] = f[i*8 +: 8];
      par = par ^ exp_ph[i];
    end
    exp_ph[8] = par;
    nph_tot = 8 + PARN;
    flit_in = f; flit_valid = 1'b1; phy_ready = 1'b1;
    k = 0; cyc = 0; stalls = 0;
    while (k < nph_tot && cyc < 60) begin
      tick();
      cyc++;
      phy_ready = !(cyc >= st_lo && cyc <= st_hi);
      if (!phy_ready) stalls++;
      check_eq({tag, "_valid"}, phy_valid, 1'b1);
      check_eq({tag, "_data"}, phy_data, exp_ph[k]);
      check_eq({tag, "_early_sent"}, packet_sent, 1'b0);
      got_phits[k] = phy_data;
      if (phy_ready) k++;
    end
    check_eq({tag, "_phit_count"}, k, nph_tot);
    tick();
    cyc++;
    phy_ready = 1'b1;
    check_eq({tag, "_sent"}, packet_sent, 1'b1);
    check_eq({tag, "_done_valid"}, phy_valid, 1'b0);
    check_eq({tag, "_done_data"}, phy_data, 8'h00);
    check_eq({tag, "_sent_cycle"}, cyc, nph_tot + 1 + stalls);
  endtask

  initial begin
    logic [7:0]  t1_exp [0:7];
    logic [23:0] exp24 [0:3];
    t1_exp = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
    exp24  = '{24'hABCDEF, 24'h456789, 24'h000123, 24'hEEAB45};

    repeat (3) tick();
    check_eq("rst_valid", phy_valid, 1'b0);
    check_eq("rst_data", phy_data, 8'h00);
    check_eq("rst_sent", packet_sent, 1'b0);
    check_eq("rst_credit", credit_granted, 2'b00);
    n_rst = 1'b0;
    tick();

    // Basic flit, held through DONE, dropped the cycle after packet_sent.
    send_and_check(F1, 0, -1, "t1");
    for (int i = 0; i < 8; i++) check_eq("t1_phit_table", got_phits[i], t1_exp[i]);
`ifdef SWITCH_LINK_TX_PARITY_EN
    check_eq("t1_parity", got_phits[8], 8'h00);
`endif
    tick();
    flit_valid = 1'b0;
    check_eq("t1_idle_valid", phy_valid, 1'b0);
    tick();
    check_eq("t1_no_recapture", phy_valid, 1'b0);
    tick();
    check_eq("t1_no_recapture2", phy_valid, 1'b0);

    // Stall on cycles 3..5, then back-to-back second flit with flit_valid held.
    send_and_check(F1, 3, 5, "t2");
    flit_in = F2;
    tick();
    check_eq("t3_gap_valid", phy_valid, 1'b0);
    send_and_check(F2, 0, -1, "t3");
    tick();
    flit_valid = 1'b0;

    // Credits while idle.
    phy_credit_in = 2'b11;
    tick();
    check_eq("cr_idle_11", credit_granted, 2'b11);
    phy_credit_in = 2'b01;
    tick();
    check_eq("cr_idle_01a", credit_granted, 2'b01);
    tick();
    check_eq("cr_idle_01b", credit_granted, 2'b01);
    phy_credit_in = 2'b00;
    tick();
    check_eq("cr_idle_00", credit_granted, 2'b00);

    // Credits mid-flit, plus flit_valid dropped during SEND.
    fork
      send_and_check(F1, 0, -1, "t4");
      begin
        tick();
        tick();
        flit_valid = 1'b0;
        phy_credit_in = 2'b11;
        tick();
        check_eq("cr_mid_11", credit_granted, 2'b11);
        phy_credit_in = 2'b01;
        tick();
        check_eq("cr_mid_01a", credit_granted, 2'b01);
        tick();
        check_eq("cr_mid_01b", credit_granted, 2'b01);
        phy_credit_in = 2'b00;
        tick();
        check_eq("cr_mid_00", credit_granted, 2'b00);
      end
    join
    tick();

    // Reset during phit 4.
    flit_in = F2; flit_valid = 1'b1; phy_ready = 1'b1;
    repeat (4) tick();
    check_eq("rst4_phit", phy_data, 8'hFF);
    n_rst = 1'b1; phy_credit_in = 2'b11; flit_valid = 1'b0;
    tick();
    check_eq("rst4_valid", phy_valid, 1'b0);
    check_eq("rst4_data", phy_data, 8'h00);
    check_eq("rst4_credit", credit_granted, 2'b00);
    check_eq("rst4_sent", packet_sent, 1'b0);
    n_rst = 1'b0; phy_credit_in = 2'b00;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_eq("post_rst_sent", packet_sent, 1'b0);
      check_eq("post_rst_valid", phy_valid, 1'b0);
      check_eq("post_rst_credit", credit_granted, 2'b00);
    end
    send_and_check(F1, 0, -1, "t5");
    tick();
    flit_valid = 1'b0;

    // 24-bit phits: three phits, last one padded with zeros.
    flit_in24 = F1; flit_valid24 = 1'b1; phy_ready24 = 1'b1;
    for (int c = 0; c < 3 + PARN; c++) begin
      tick();
      flit_valid24 = 1'b0;
      check_eq("w24_valid", phy_valid24, 1'b1);
      check_eq("w24_data", phy_data24, exp24[c]);
      check_eq("w24_early_sent", packet_sent24, 1'b0);
    end
    tick();
    check_eq("w24_sent", packet_sent24, 1'b1);
    check_eq("w24_done_valid", phy_valid24, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
